// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, state encoding and enable helper for the segment scanner
package seg_pkg;

  localparam logic [7:0] SEG_ZERO = 8'h3F;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Enable pattern with every digit dark, for either enable polarity.
  function automatic logic [3:0] an_off(input logic active_low);
    return active_low ? 4'hF : 4'h0;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - phase counter, BLANK/SHOW sequencing, digit index and frame-boundary strobe
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  output state_t     state,
  output logic [1:0] idx,
  output logic       boundary
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  // Alternate blank gap and lit slot; the digit index advances as each lit slot ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= idx + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

  // First blank cycle ahead of digit 0 is the only point a new word may take effect.
  assign boundary = (state == BLANK) && (idx == 2'd0) && (cnt == '0);

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - captures converter words and multiplexes four digits onto one segment bus; SEG_SCAN_LZB_EN enables leading-zero blanking
module seg_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 500,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic        conv_done,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_upd
);

  localparam logic       ACT_LOW = (AN_ACTIVE_LOW != 0);
  localparam logic [3:0] AN_OFF  = an_off(ACT_LOW);

  state_t      state;
  logic [1:0]  idx;
  logic        boundary;

  logic [31:0] active;
  logic [31:0] pending;
  logic        pend_v;
  logic [3:0]  lz_blank;
  logic [3:0]  lit;

  seg_scan_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .idx      (idx),
    .boundary (boundary)
  );

  // Hold the newest converter word; it only reaches the display at a frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 32'h0;
      pending <= 32'h0;
      pend_v  <= 1'b0;
    end else begin
      if (conv_done) begin
        pending <= digits;
      end
      if (boundary) begin
        if (conv_done) begin
          active <= digits;
        end else if (pend_v) begin
          active <= pending;
        end
        pend_v <= 1'b0;
      end else if (conv_done) begin
        pend_v <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // A digit is dark when it shows zero and every digit to its left is dark too.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (active[31:24] == SEG_ZERO);
    lz_blank[2] = lz_blank[3] && (active[23:16] == SEG_ZERO);
    lz_blank[1] = lz_blank[2] && (active[15:8] == SEG_ZERO);
  end
`else
  assign lz_blank = 4'b0000;
`endif

  assign lit = 4'b0001 << idx;

  // Register the drive so the pins never see a combinational path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg       <= SEG_OFF;
      an        <= AN_OFF;
      frame_upd <= 1'b0;
    end else begin
      frame_upd <= boundary && (pend_v || conv_done);
      if ((state == SHOW) && !lz_blank[idx]) begin
        seg <= active[{idx, 3'b000} +: 8];
        an  <= ACT_LOW ? ~lit : lit;
      end else begin
        seg <= SEG_OFF;
        an  <= AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - randomized and directed self-checking bench for seg_scan against a frame-position model
module tb_seg_scan;

  localparam int RD = 4;
  localparam int BC = 1;
  localparam int DP = RD + BC;
  localparam int FR = 4 * DP;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] digits;
  logic        conv_done;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_upd;

  int checks = 0;
  int errors = 0;

  int          n;
  logic [31:0] m_active;
  logic [31:0] m_pend;
  logic        m_pv;

  seg_scan #(
    .REFRESH_DIV   (RD),
    .BLANK_CYCLES  (BC),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits    (digits),
    .conv_done (conv_done),
    .seg       (seg),
    .an        (an),
    .frame_upd (frame_upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at n=%0d", tag, obs, exp, n);
    end
  endtask

  // Expected display for a position inside the frame, from the digit slot layout.
  function automatic void model_out(input int p, input logic [31:0] w,
                                    output logic [7:0] s, output logic [3:0] a);
    int   d;
    logic dark;
    d = p / DP;
    if ((p % DP) < BC) begin
      s = 8'h00;
      a = 4'hF;
    end else begin
      dark = 1'b0;
`ifdef SEG_SCAN_LZB_EN
      if (d > 0) begin
        dark = 1'b1;
        for (int k = d; k < 4; k++)
          if (w[k*8 +: 8] != 8'h3F) dark = 1'b0;
      end
`endif
      if (dark) begin
        s = 8'h00;
        a = 4'hF;
      end else begin
        s = w[d*8 +: 8];
        a = ~(4'b0001 << d);
      end
    end
  endfunction

  task automatic model_reset();
    n        = 0;
    m_active = 32'h0;
    m_pend   = 32'h0;
    m_pv     = 1'b0;
  endtask

  task automatic cycle(input logic cd, input logic [31:0] d);
    logic [7:0] es;
    logic [3:0] ea;
    logic       eu;
    int         p;
    conv_done = cd;
    digits    = d;
    @(posedge clk);
    p = n % FR;
    model_out(p, m_active, es, ea);
    eu = (p == 0) && (m_pv || cd);
    if (p == 0) begin
      if (cd) m_active = d;
      else if (m_pv) m_active = m_pend;
      m_pv = 1'b0;
    end else if (cd) begin
      m_pend = d;
      m_pv   = 1'b1;
    end
    n++;
    #1;
    chk("seg", {24'h0, seg}, {24'h0, es});
    chk("an", {28'h0, an}, {28'h0, ea});
    chk("frame_upd", {31'h0, frame_upd}, {31'h0, eu});
  endtask

  task automatic idle();
    cycle(1'b0, $urandom);
  endtask

  task automatic run_to(input int p);
    while ((n % FR) != p) idle();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[k*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'h3F : 8'($urandom);
    return w;
  endfunction

  initial begin
    rst       = 1'b1;
    conv_done = 1'b0;
    digits    = 32'h0;
    model_reset();
    #1;
    chk("reset_seg", {24'h0, seg}, 32'h0);
    chk("reset_an", {28'h0, an}, 32'hF);
    chk("reset_upd", {31'h0, frame_upd}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    repeat (40) idle();

    run_to(7);
    cycle(1'b1, 32'h4F5B063F);
    repeat (40) idle();

    run_to(3);
    cycle(1'b1, 32'h11111111);
    repeat (3) idle();
    cycle(1'b1, 32'h22222222);
    repeat (40) idle();

    run_to(0);
    cycle(1'b1, 32'h741C507C);
    repeat (40) idle();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) cycle(1'b1, rand_word());
      else idle();
    end

    run_to(12);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_seg", {24'h0, seg}, 32'h0);
    chk("midreset_an", {28'h0, an}, 32'hF);
    chk("midreset_upd", {31'h0, frame_upd}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (40) idle();

    run_to(5);
    cycle(1'b1, 32'h3F3F063F);
    repeat (45) idle();

    run_to(9);
    cycle(1'b1, 32'h3F3F3F3F);
    repeat (45) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
